// File: rtl/lcd_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lcd_write_arbiter
// Purpose  : Round-robin arbiter sharing the LCD write path among NUM_REQ
//            display-field writers. One requester is granted per burst; its
//            bytes are streamed to the LCD sequencer as {page, column, byte}
//            beats, and the column/page auto-advance with wrap.
// Ports    : clock, reset_n            - clock, async active-low reset
//            req/req_page/req_col/req_len - burst request and its geometry
//            req_data/req_data_valid/req_data_ready - per-requester byte stream
//            gnt, done                 - one-hot grant, burst-complete pulse
//            wr_valid/wr_ready, position_y/position_x/ascii - beat to sequencer
//            busy                      - arbiter not idle
// Revision : 1.0 - initial release
// ============================================================================
module lcd_write_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_COL  = 131,
  parameter int MAX_PAGE = 7
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [4*NUM_REQ-1:0]   req_page,
  input  logic [8*NUM_REQ-1:0]   req_col,
  input  logic [8*NUM_REQ-1:0]   req_len,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_data_valid,
  output logic [NUM_REQ-1:0]     req_data_ready,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic [3:0]             position_y,
  output logic [7:0]             position_x,
  output logic [7:0]             ascii,
  output logic                   busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gidx;
  logic [3:0]       page;
  logic [7:0]       col;
  logic [7:0]       cnt;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             take_ok;
  logic             take;
  logic [7:0]       cur_data;

  // Round-robin pick: scan rr_ptr, rr_ptr+1, ... and keep the first set bit.
  // Iterating from the far end lets the nearest requester overwrite last.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(j);
      end
    end
  end

  // Single output register: a new byte may be taken whenever the register is
  // empty or is being emptied this cycle, so streaming has no bubble.
  assign take_ok  = (state == S_STREAM) && (!wr_valid || wr_ready);
  assign take     = take_ok && req_data_valid[gidx];
  assign cur_data = req_data[8*int'(gidx) +: 8];

  always_comb begin
    req_data_ready       = '0;
    req_data_ready[gidx] = take_ok;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      gidx       <= '0;
      page       <= '0;
      col        <= '0;
      cnt        <= '0;
      gnt        <= '0;
      done       <= '0;
      wr_valid   <= 1'b0;
      position_y <= '0;
      position_x <= '0;
      ascii      <= '0;
      busy       <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            gidx          <= pick_idx;
            page          <= req_page[4*int'(pick_idx) +: 4];
            col           <= req_col[8*int'(pick_idx) +: 8];
            cnt           <= req_len[8*int'(pick_idx) +: 8];
            gnt           <= '0;
            gnt[pick_idx] <= 1'b1;
            busy          <= 1'b1;
            // Zero-length bursts skip streaming entirely.
            state <= (req_len[8*int'(pick_idx) +: 8] == 8'd0) ? S_DONE : S_STREAM;
          end
        end

        S_STREAM: begin
          if (wr_valid && wr_ready) wr_valid <= 1'b0;
          if (take) begin
            position_y <= page;
            position_x <= col;
            ascii      <= cur_data;
            wr_valid   <= 1'b1;
            cnt        <= cnt - 8'd1;
            if (col == 8'(MAX_COL)) begin
              col  <= '0;
              page <= (page == 4'(MAX_PAGE)) ? 4'd0 : page + 4'd1;
            end else begin
              col <= col + 8'd1;
            end
            if (cnt == 8'd1) state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (wr_valid && wr_ready) begin
            wr_valid <= 1'b0;
            state    <= S_DONE;
          end
        end

        S_DONE: begin
          done[gidx] <= 1'b1;
          gnt        <= '0;
          busy       <= 1'b0;
          rr_ptr     <= (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_write_arbiter
// Purpose  : Directed self-checking bench for lcd_write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lcd_write_arbiter;

  localparam int N = 4;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [4*N-1:0] req_page = '0;
  logic [8*N-1:0] req_col = '0;
  logic [8*N-1:0] req_len = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_data_valid = '0;
  logic [N-1:0]   req_data_ready;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           wr_valid;
  logic           wr_ready = 1'b1;
  logic [3:0]     position_y;
  logic [7:0]     position_x;
  logic [7:0]     ascii;
  logic           busy;

  int tests = 0;
  int fails = 0;

  logic [3:0] cap_y [16];
  logic [7:0] cap_x [16];
  logic [7:0] cap_a [16];
  int         ncap;

  lcd_write_arbiter #(.NUM_REQ(N), .MAX_COL(131), .MAX_PAGE(7)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_page(req_page),
    .req_col(req_col), .req_len(req_len), .req_data(req_data),
    .req_data_valid(req_data_valid), .req_data_ready(req_data_ready),
    .gnt(gnt), .done(done), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .position_y(position_y), .position_x(position_x), .ascii(ascii), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic setup_req(input int g, input logic [3:0] pg, input logic [7:0] cl,
                           input logic [7:0] ln);
    @(negedge clock);
    req_page[4*g +: 4] = pg;
    req_col[8*g +: 8]  = cl;
    req_len[8*g +: 8]  = ln;
    req[g]             = 1'b1;
  endtask

  // Acts as requester g and as the LCD sequencer. Optionally holds wr_ready
  // low for stall_len cycles once stall_at beats have been accepted.
  task automatic drive_burst(input int g, input logic [7:0] base, input int stall_at,
                             input int stall_len, output int gnt_cyc, output int wv_cyc,
                             output int done_cyc);
    int idx = 0;
    int cyc = 0;
    int stall_cnt = 0;
    bit fin = 0;
    logic [19:0] held = '0;
    gnt_cyc = 0; wv_cyc = 0; done_cyc = 0; ncap = 0;
    while (!fin && cyc < 300) begin
      @(negedge clock);
      cyc++;
      req_data[8*g +: 8] = base + 8'(idx);
      req_data_valid     = '0;
      req_data_valid[g]  = 1'b1;
      if (wr_valid && ncap == stall_at && stall_cnt < stall_len) begin
        wr_ready = 1'b0;
        if (stall_cnt == 0) held = {position_y, position_x, ascii};
        stall_cnt++;
      end else begin
        wr_ready = 1'b1;
      end
      #1;
      if (!wr_ready) begin
        tests++;
        if ({position_y, position_x, ascii} !== held || req_data_ready[g] !== 1'b0) begin
          fails++;
          $display("FAIL stall_hold: beat=%h ready=%b required beat=%h ready=0",
                   {position_y, position_x, ascii}, req_data_ready[g], held);
        end
      end
      if ((req_data_ready & ~gnt) != '0) begin
        tests++; fails++;
        $display("FAIL ready_leak: ready=%b gnt=%b required ready subset of gnt",
                 req_data_ready, gnt);
      end
      if (gnt[g]) begin gnt_cyc++; req[g] = 1'b0; end
      if (wr_valid) wv_cyc++;
      if (done[g]) begin done_cyc++; fin = 1; end
      if (wr_valid && wr_ready && ncap < 16) begin
        cap_y[ncap] = position_y; cap_x[ncap] = position_x; cap_a[ncap] = ascii;
        ncap++;
      end
      if (req_data_ready[g] && req_data_valid[g]) idx++;
    end
    req_data_valid = '0;
    wr_ready = 1'b1;
    tests++;
    if (!fin) begin
      fails++;
      $display("FAIL burst_timeout: done[%0d] not seen within 300 cycles", g);
    end else begin
      @(negedge clock); #1;
      if (done !== '0) begin
        fails++;
        $display("FAIL done_pulse_width: done=%b one cycle later, required 0", done);
      end
    end
  endtask

  task automatic check_beat(input string nm, input int k, input logic [3:0] y,
                            input logic [7:0] x, input logic [7:0] a);
    tests++;
    if (k >= ncap || cap_y[k] !== y || cap_x[k] !== x || cap_a[k] !== a) begin
      fails++;
      $display("FAIL %s beat%0d: got (%0d,%0d,%h) of %0d beats, required (%0d,%0d,%h)",
               nm, k, cap_y[k], cap_x[k], cap_a[k], ncap, y, x, a);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    tests++;
    if (gnt !== '0 || done !== '0 || wr_valid !== 1'b0 || busy !== 1'b0 ||
        req_data_ready !== '0 || position_y !== 4'd0 || position_x !== 8'd0 || ascii !== 8'd0) begin
      fails++;
      $display("FAIL reset_state: gnt=%b done=%b wv=%b busy=%b rdy=%b pos=(%0d,%0d,%h) required all 0",
               gnt, done, wr_valid, busy, req_data_ready, position_y, position_x, ascii);
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_round_robin();
    logic [N-1:0] order [4];
    logic [N-1:0] prev = '0;
    int n = 0;
    int cyc = 0;
    @(negedge clock);
    req_len = {8'd1, 8'd1, 8'd1, 8'd1};
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req_data_valid = '1;
    wr_ready = 1'b1;
    req = '1;
    while (n < 4 && cyc < 80) begin
      @(negedge clock); #1;
      cyc++;
      if (gnt != '0 && prev == '0) begin order[n] = gnt; n++; end
      prev = gnt;
    end
    req = '0;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (k >= n || order[k] !== (4'b0001 << k)) begin
        fails++;
        $display("FAIL rr_order grant%0d: got %b (of %0d grants), required %b",
                 k, order[k], n, 4'b0001 << k);
      end
    end
    cyc = 0;
    while ((busy || done != '0) && cyc < 20) begin @(negedge clock); #1; cyc++; end
    req_data_valid = '0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_single_burst();
    int gc, wc, dc;
    setup_req(1, 4'd2, 8'd10, 8'd3);
    drive_burst(1, 8'h41, -1, 0, gc, wc, dc);
    check_beat("single", 0, 4'd2, 8'd10, 8'h41);
    check_beat("single", 1, 4'd2, 8'd11, 8'h42);
    check_beat("single", 2, 4'd2, 8'd12, 8'h43);
    tests++;
    if (gc != 5 || dc != 1 || ncap != 3) begin
      fails++;
      $display("FAIL single_counts: gnt_cycles=%0d done=%0d beats=%0d required 5,1,3", gc, dc, ncap);
    end
  endtask

  task automatic test_backpressure();
    int gc, wc, dc;
    setup_req(0, 4'd3, 8'd50, 8'd4);
    drive_burst(0, 8'h30, 1, 5, gc, wc, dc);
    check_beat("bp", 0, 4'd3, 8'd50, 8'h30);
    check_beat("bp", 1, 4'd3, 8'd51, 8'h31);
    check_beat("bp", 2, 4'd3, 8'd52, 8'h32);
    check_beat("bp", 3, 4'd3, 8'd53, 8'h33);
    tests++;
    if (ncap != 4) begin
      fails++;
      $display("FAIL bp_beats: got %0d beats, required 4", ncap);
    end
  endtask

  task automatic test_wrap();
    int gc, wc, dc;
    setup_req(3, 4'd7, 8'd130, 8'd3);
    drive_burst(3, 8'h61, -1, 0, gc, wc, dc);
    check_beat("wrap", 0, 4'd7, 8'd130, 8'h61);
    check_beat("wrap", 1, 4'd7, 8'd131, 8'h62);
    check_beat("wrap", 2, 4'd0, 8'd0,   8'h63);
  endtask

  task automatic test_zero_len();
    int gc, wc, dc;
    setup_req(2, 4'd1, 8'd5, 8'd0);
    drive_burst(2, 8'h00, -1, 0, gc, wc, dc);
    tests++;
    if (gc != 1 || wc != 0 || dc != 1) begin
      fails++;
      $display("FAIL zero_len: gnt_cycles=%0d wr_valid_cycles=%0d done=%0d required 1,0,1", gc, wc, dc);
    end
  endtask

  task automatic test_reset_mid_burst();
    int acc = 0;
    int idx = 0;
    int cyc = 0;
    setup_req(3, 4'd1, 8'd0, 8'd5);
    while (acc < 2 && cyc < 50) begin
      @(negedge clock);
      cyc++;
      req_data[31:24] = 8'h70 + 8'(idx);
      req_data_valid = 4'b1000;
      wr_ready = 1'b1;
      #1;
      if (gnt[3]) req[3] = 1'b0;
      if (wr_valid && wr_ready) acc++;
      if (req_data_ready[3]) idx++;
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if (acc != 2 || wr_valid !== 1'b0 || gnt !== '0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: beats=%0d wv=%b gnt=%b busy=%b required 2,0,0,0",
               acc, wr_valid, gnt, busy);
    end
    req_data_valid = '0;
    @(negedge clock);
    reset_n = 1'b1;
    req_len = {8'd1, 8'd1, 8'd1, 8'd1};
    req = 4'b1010;
    req_data_valid = 4'b1010;
    cyc = 0;
    do begin @(negedge clock); #1; cyc++; end while (gnt == '0 && cyc < 20);
    tests++;
    if (gnt !== 4'b0010) begin
      fails++;
      $display("FAIL reset_rr_ptr: first grant after reset %b, required 0010", gnt);
    end
    req = '0;
    cyc = 0;
    while ((busy || done != '0) && cyc < 20) begin @(negedge clock); #1; cyc++; end
    req_data_valid = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_burst();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_reset_mid_burst();
    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
